// File: rtl/jtag_pkg.sv
// Shared types for the button-stepped TAP controller: TAP state encodings
// and the BYPASS instruction helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'h0,
        RTI      = 4'h1,
        SEL_DR   = 4'h2,
        CAP_DR   = 4'h3,
        SH_DR    = 4'h4,
        EX1_DR   = 4'h5,
        PAUSE_DR = 4'h6,
        EX2_DR   = 4'h7,
        UPD_DR   = 4'h8,
        SEL_IR   = 4'h9,
        CAP_IR   = 4'hA,
        SH_IR    = 4'hB,
        EX1_IR   = 4'hC,
        PAUSE_IR = 4'hD,
        EX2_IR   = 4'hE,
        UPD_IR   = 4'hF
    } tap_state_t;

    localparam int unsigned MAX_REG_W = 64;

    // All-ones instruction of the requested width; callers cast to their IR width.
    function automatic logic [MAX_REG_W-1:0] BYPASS_INSTR(input int unsigned width);
        return {MAX_REG_W{1'b1}} >> (MAX_REG_W - width);
    endfunction

endpackage

// File: rtl/jtag_tap_stepper_if.sv
// Step/TMS/TDI inputs and display outputs of the stepped TAP, as one bundle.
interface jtag_tap_stepper_if
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W = 4,
    parameter int unsigned DR_W = 8
);
    logic            step;
    logic            tms;
    logic            tdi;
    logic            tdo;
    tap_state_t      state;
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr;
    logic            upd_dr;

    modport master (
        output step, tms, tdi,
        input  tdo, state, ir, dr, upd_dr
    );

    modport slave (
        input  step, tms, tdi,
        output tdo, state, ir, dr, upd_dr
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state register, advanced once per step pulse.
// ns is the state the next step would enter, exported for the datapath.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step,
    input  logic       tms,
    output tap_state_t state,
    output tap_state_t ns
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= TLR;
        end else if (step) begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign ns    = state_d;

endmodule

// File: rtl/jtag_tap_stepper.sv
// Button-stepped TAP controller: each step pulse is one TCK rising edge that
// advances the TAP FSM and captures/shifts/updates the IR, user DR or bypass bit.
module jtag_tap_stepper
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W = 4,
    parameter int unsigned DR_W = 8
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    jtag_tap_stepper_if.slave     tap_if
);

    localparam logic [IR_W-1:0] BYPASS = IR_W'(BYPASS_INSTR(IR_W));

    tap_state_t state;
    tap_state_t ns;

    logic [IR_W-1:0] ir_q,    ir_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic [DR_W-1:0] dr_q,    dr_d;
    logic [DR_W-1:0] dr_sr_q, dr_sr_d;
    logic            bypass_q, bypass_d;
    logic            tdo_q,    tdo_d;
    logic            upd_dr_q, upd_dr_d;
    logic            is_bypass;

    jtag_tap_fsm u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (tap_if.step),
        .tms     (tap_if.tms),
        .state   (state),
        .ns      (ns)
    );

    assign is_bypass = (ir_q == BYPASS);

    // Capture/shift act on the state left by this step; updates on the state entered.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        ir_d     = ir_q;
        ir_sr_d  = ir_sr_q;
        dr_d     = dr_q;
        dr_sr_d  = dr_sr_q;
        bypass_d = bypass_q;
        tdo_d    = tdo_q;
        upd_dr_d = 1'b0;

        if (tap_if.step) begin
            case (state)
                CAP_IR: ir_sr_d = IR_W'(2'b01);
                CAP_DR: begin
                    if (is_bypass) bypass_d = 1'b0;
                    else           dr_sr_d  = dr_q;
                end
                SH_IR: begin
                    tdo_d   = ir_sr_q[0];
                    ir_sr_d = {tap_if.tdi, ir_sr_q[IR_W-1:1]};
                end
                SH_DR: begin
                    if (is_bypass) begin
                        tdo_d    = bypass_q;
                        bypass_d = tap_if.tdi;
                    end else begin
                        tdo_d   = dr_sr_q[0];
                        dr_sr_d = {tap_if.tdi, dr_sr_q[DR_W-1:1]};
                    end
                end
                default: ;
            endcase

            if (ns == UPD_IR) begin
                ir_d = ir_sr_q;
            end
            if (ns == UPD_DR && !is_bypass) begin
                dr_d     = dr_sr_q;
                upd_dr_d = 1'b1;
            end
            if (ns == TLR) begin
                ir_d = BYPASS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_q     <= BYPASS;
            ir_sr_q  <= '0;
            dr_q     <= '0;
            dr_sr_q  <= '0;
            bypass_q <= 1'b0;
            tdo_q    <= 1'b0;
            upd_dr_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            dr_q     <= dr_d;
            dr_sr_q  <= dr_sr_d;
            bypass_q <= bypass_d;
            tdo_q    <= tdo_d;
            upd_dr_q <= upd_dr_d;
        end
    end

    assign tap_if.state  = state;
    assign tap_if.ir     = ir_q;
    assign tap_if.dr     = dr_q;
    assign tap_if.tdo    = tdo_q;
    assign tap_if.upd_dr = upd_dr_q;

endmodule

// File: tb/tb_jtag_tap_stepper.sv
// Self-checking bench for jtag_tap_stepper: directed vector table, hand-written
// corner sequences, then random stepping against a table-based TAP model.
module tb_jtag_tap_stepper;

    localparam int unsigned IR_W = 4;
    localparam int unsigned DR_W = 8;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       tdo;
        logic [3:0] ir;
        logic [7:0] dr;
        logic       upd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    // Reference model: TAP successor tables indexed by state, plus register contents.
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int          m_st;
    int unsigned m_ir, m_ir_sr, m_dr, m_dr_sr;
    bit          m_byp, m_tdo, m_upd;

    localparam int unsigned IR_ALL = (1 << IR_W) - 1;

    jtag_tap_stepper_if #(.IR_W(IR_W), .DR_W(DR_W)) bus ();

    jtag_tap_stepper #(.IR_W(IR_W), .DR_W(DR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tap_if  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] dut_pack();
        return {bus.state, bus.tdo, bus.ir, bus.dr, bus.upd_dr};
    endfunction

    function automatic logic [17:0] model_pack();
        return {4'(m_st), m_tdo, 4'(m_ir), 8'(m_dr), m_upd};
    endfunction

    // Drive one clk cycle's inputs at a falling edge; outputs are read at the next one.
    task automatic cycle(input logic rst_v, input logic step_v, input logic tms_v, input logic tdi_v);
        reset_n  = rst_v;
        bus.step = step_v;
        bus.tms  = tms_v;
        bus.tdi  = tdi_v;
        @(negedge clk);
    endtask

    task automatic model_cycle(input bit rst_v, input bit step_v, input bit tms_v, input bit tdi_v);
        int  nst;
        bit  byp_ir;
        if (!rst_v) begin
            m_st = 0; m_ir = IR_ALL; m_dr = 0; m_tdo = 0; m_upd = 0;
            m_ir_sr = 0; m_dr_sr = 0; m_byp = 0;
            return;
        end
        m_upd = 0;
        if (!step_v) return;
        nst    = tms_v ? nxt1[m_st] : nxt0[m_st];
        byp_ir = (m_ir == IR_ALL);
        if (m_st == 10) m_ir_sr = 1;
        if (m_st == 3) begin
            if (byp_ir) m_byp = 0;
            else        m_dr_sr = m_dr;
        end
        if (m_st == 11) begin
            m_tdo   = m_ir_sr[0];
            m_ir_sr = (m_ir_sr >> 1) | (int'(tdi_v) << (IR_W - 1));
        end
        if (m_st == 4) begin
            if (byp_ir) begin
                m_tdo = m_byp;
                m_byp = tdi_v;
            end else begin
                m_tdo   = m_dr_sr[0];
                m_dr_sr = (m_dr_sr >> 1) | (int'(tdi_v) << (DR_W - 1));
            end
        end
        if (nst == 15) m_ir = m_ir_sr;
        if (nst == 8 && !byp_ir) begin
            m_dr  = m_dr_sr;
            m_upd = 1;
        end
        if (nst == 0) m_ir = IR_ALL;
        m_st = nst;
    endtask

    task automatic add(input logic tms, input logic tdi, input logic [3:0] st, input logic tdo,
                       input logic [3:0] ir, input logic [7:0] dr, input logic upd);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.st = st; v.tdo = tdo; v.ir = ir; v.dr = dr; v.upd = upd;
        vecs.push_back(v);
    endtask

    initial begin
        // Bypass capture, then five tms=1 steps from ShDR, and one more in TLR.
        add(0,0,4'h1,0,4'hF,8'h00,0); add(1,0,4'h2,0,4'hF,8'h00,0);
        add(0,0,4'h3,0,4'hF,8'h00,0); add(0,0,4'h4,0,4'hF,8'h00,0);
        add(1,0,4'h5,0,4'hF,8'h00,0); add(1,0,4'h8,0,4'hF,8'h00,0);
        add(1,0,4'h2,0,4'hF,8'h00,0); add(1,0,4'h9,0,4'hF,8'h00,0);
        add(1,0,4'h0,0,4'hF,8'h00,0); add(1,0,4'h0,0,4'hF,8'h00,0);
        // IR load of 4'h2.
        add(0,0,4'h1,0,4'hF,8'h00,0); add(1,0,4'h2,0,4'hF,8'h00,0);
        add(1,0,4'h9,0,4'hF,8'h00,0); add(0,0,4'hA,0,4'hF,8'h00,0);
        add(0,0,4'hB,0,4'hF,8'h00,0); add(0,0,4'hB,1,4'hF,8'h00,0);
        add(0,1,4'hB,0,4'hF,8'h00,0); add(0,0,4'hB,0,4'hF,8'h00,0);
        add(1,0,4'hC,0,4'hF,8'h00,0); add(1,0,4'hF,0,4'h2,8'h00,0);
        // Write 8'hA5 LSB first.
        add(1,0,4'h2,0,4'h2,8'h00,0); add(0,0,4'h3,0,4'h2,8'h00,0);
        add(0,0,4'h4,0,4'h2,8'h00,0);
        add(0,1,4'h4,0,4'h2,8'h00,0); add(0,0,4'h4,0,4'h2,8'h00,0);
        add(0,1,4'h4,0,4'h2,8'h00,0); add(0,0,4'h4,0,4'h2,8'h00,0);
        add(0,0,4'h4,0,4'h2,8'h00,0); add(0,1,4'h4,0,4'h2,8'h00,0);
        add(0,0,4'h4,0,4'h2,8'h00,0); add(1,1,4'h5,0,4'h2,8'h00,0);
        add(1,0,4'h8,0,4'h2,8'hA5,1); add(1,0,4'h2,0,4'h2,8'hA5,0);
        // Recapture and read back.
        add(0,0,4'h3,0,4'h2,8'hA5,0); add(0,0,4'h4,0,4'h2,8'hA5,0);
        add(0,0,4'h4,1,4'h2,8'hA5,0); add(0,0,4'h4,0,4'h2,8'hA5,0);
        add(0,0,4'h4,1,4'h2,8'hA5,0); add(0,0,4'h4,0,4'h2,8'hA5,0);
        add(0,0,4'h4,0,4'h2,8'hA5,0); add(0,0,4'h4,1,4'h2,8'hA5,0);
        add(0,0,4'h4,0,4'h2,8'hA5,0); add(1,0,4'h5,1,4'h2,8'hA5,0);
        // Pause/Ex2 paths, update through Ex2.
        add(0,0,4'h6,1,4'h2,8'hA5,0); add(1,0,4'h7,1,4'h2,8'hA5,0);
        add(0,0,4'h4,1,4'h2,8'hA5,0); add(1,1,4'h5,0,4'h2,8'hA5,0);
        add(0,0,4'h6,0,4'h2,8'hA5,0); add(1,0,4'h7,0,4'h2,8'hA5,0);
        add(1,0,4'h8,0,4'h2,8'h80,1); add(1,0,4'h2,0,4'h2,8'h80,0);
        // Back to TLR (ir forced to BYPASS), then bypass shift 1,0,1.
        add(1,0,4'h9,0,4'h2,8'h80,0); add(1,0,4'h0,0,4'hF,8'h80,0);
        add(0,0,4'h1,0,4'hF,8'h80,0); add(1,0,4'h2,0,4'hF,8'h80,0);
        add(0,0,4'h3,0,4'hF,8'h80,0); add(0,0,4'h4,0,4'hF,8'h80,0);
        add(0,1,4'h4,0,4'hF,8'h80,0); add(0,0,4'h4,1,4'hF,8'h80,0);
        add(1,1,4'h5,0,4'hF,8'h80,0); add(1,0,4'h8,0,4'hF,8'h80,0);
        add(0,0,4'h1,0,4'hF,8'h80,0);

        @(negedge clk);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        check("reset", dut_pack(), {4'h0, 1'b0, 4'hF, 8'h00, 1'b0});

        foreach (vecs[i]) begin
            cycle(1, 1, vecs[i].tms, vecs[i].tdi);
            check($sformatf("vec%0d", i), dut_pack(),
                  {vecs[i].st, vecs[i].tdo, vecs[i].ir, vecs[i].dr, vecs[i].upd});
        end

        // Idle cycles with wiggling tms/tdi must change nothing.
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 1'($urandom), 1'($urandom));
            check($sformatf("idle%0d", i), dut_pack(), {4'h1, 1'b0, 4'hF, 8'h80, 1'b0});
        end

        // step held high for three consecutive cycles with tms=1 from RTI.
        cycle(1, 1, 1, 0);
        check("held1", 64'(bus.state), 64'h2);
        cycle(1, 1, 1, 0);
        check("held2", 64'(bus.state), 64'h9);
        cycle(1, 1, 1, 0);
        check("held3", 64'(bus.state), 64'h0);
        cycle(1, 0, 0, 0);

        // Reset in the middle of a DR shift.
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("pre_rst_state", 64'(bus.state), 64'h4);
        cycle(1, 1, 0, 1);
        cycle(0, 1, 0, 1);
        check("mid_shift_rst", dut_pack(), {4'h0, 1'b0, 4'hF, 8'h00, 1'b0});

        // Random stepping against the model.
        model_cycle(0, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, s, t, d;
            r = ($urandom_range(0, 299) != 0);
            s = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 9) < 4);
            d = 1'($urandom);
            cycle(r, s, t, d);
            model_cycle(r, s, t, d);
            check($sformatf("rand%0d", i), dut_pack(), model_pack());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_stepper.md
# jtag_tap_stepper

Button-stepped IEEE 1149.1-style TAP controller with instruction and data registers. Sits directly downstream of the button-pulse conditioner: each one-cycle `step` pulse acts as one TCK rising edge. The TMS/TDI switch values sampled on that edge advance the 16-state TAP machine and shift the IR or the selected DR. The current state, IR, DR and TDO are exported for LED/hex display.

## Interface
- `IR_W`, default 4: instruction register width; minimum 2.
- `DR_W`, default 8: user data register width; minimum 2.
- `clk`, input, 1: system clock; all logic is posedge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `step`, input, 1: one-cycle TCK-equivalent pulse from the button conditioner.
- `tms`, input, 1: test mode select; sampled only when `step`=1.
- `tdi`, input, 1: test data in; sampled only when `step`=1.
- `tdo`, output, 1: registered bit shifted out.
- `state`, output, 4: current TAP state encoding (from `jtag_pkg`).
- `ir`, output, IR_W: active instruction.
- `dr`, output, DR_W: user data register, updated in Update-DR.
- `upd_dr`, output, 1: one-cycle pulse when `dr` is written.

## Operation
- Reset (`reset_n`=0 at a clk edge) has priority over `step`. Reset values:
  - `state`=TLR
  - `ir`=all ones (BYPASS)
  - `dr`=0, `tdo`=0, `upd_dr`=0
  - IR/DR shift registers and bypass bit = 0
- Cycles with `step`=0 hold all registers. `upd_dr` returns to 0.
- Every cycle with `step`=1 is one TCK edge. The block does no edge detection: a `step` held high for N cycles counts as N steps.
- State encodings: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauseDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PauseIR=D, Ex2IR=E, UpdIR=F.
- Transitions follow standard 1149.1 (tms=1 / tms=0):
  - TLR→TLR/RTI; RTI→SelDR/RTI
  - SelDR→SelIR/CapDR; SelIR→TLR/CapIR
  - Cap→Ex1/Sh; Sh→Ex1/Sh; Ex1→Upd/Pause
  - Pause→Ex2/Pause; Ex2→Upd/Sh; Upd→SelDR/RTI
  - Five steps with tms=1 reach TLR from any state.
- Entering TLR by a step forces `ir` to all ones.
- Actions take effect on a step, keyed on the state held *before* the edge:
  - CapIR: IR shift register ← {0…0, 2'b01}.
  - CapDR: if `ir` is all ones, bypass bit ← 0; otherwise DR shift register ← `dr`.
  - ShIR: `tdo` ← ir_sr[0]; ir_sr ← {tdi, ir_sr[IR_W-1:1]}.
  - ShDR, BYPASS: `tdo` ← bypass; bypass ← tdi.
  - ShDR, other instruction: `tdo` ← dr_sr[0]; dr_sr ← {tdi, dr_sr[DR_W-1:1]}.
  - Shifting also occurs on the step that leaves Sh (tms=1).
- Update occurs on the step that enters UpdIR/UpdDR, i.e. from Ex1 or Ex2 with tms=1:
  - UpdIR: `ir` ← ir_sr.
  - UpdDR, non-BYPASS: `dr` ← dr_sr and `upd_dr`=1 for that one cycle.
  - UpdDR, BYPASS: no `dr` write and no pulse.
- `tdo` holds its last value outside shift states.

## Timing
- All outputs are registered. `state`, `tdo`, `ir`, `dr` and `upd_dr` change on the clk edge where `step`=1 is sampled, giving 1-cycle latency from `step`.
- Back-to-back steps on consecutive cycles are fully supported, with no bubbles.
- Reset mid-shift aborts the shift. Partial shift contents are discarded and `dr` is cleared.

## Structure
- Package `jtag_pkg` holds:
  - `tap_state_t`, a 4-bit enum with the encodings above;
  - `BYPASS_INSTR` helper (all ones, width-parameterised by the user).
- Sub-module `jtag_tap_fsm`: registered state plus next-state logic (inputs `clk`, `reset_n`, `step`, `tms`; outputs `state`, `ns`).
- The top level instantiates `jtag_tap_fsm` and holds the IR/DR/bypass datapath, driven from `state` and `ns`.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `step`=1 and tms=0 → `state`=0, `ir`=4'hF, `dr`=0, `tdo`=0, `upd_dr`=0.
- Five steps with tms=1 from ShDR (4) → states 5, 8, 2, 9, 0. One step with tms=1 in TLR stays at 0.
- IR load:
  - From TLR, tms sequence 0,1,1,0,0 → ShIR (B).
  - Then tdi 0,1,0,0 with tms 0,0,0,1 → `tdo` 1,0,0,0.
  - Then tms=1 → UpdIR, `ir`=4'h2.
- DR write/readback with `ir`=2:
  - Shift 8'hA5 LSB first, exit via Ex1→Upd → `upd_dr` high exactly 1 cycle, `dr`=8'hA5.
  - Recapture and shift → `tdo` 1,0,1,0,0,1,0,1.
- Bypass: with `ir`=F, in ShDR apply tdi 1,0,1 → `tdo` 0,1,0. `dr` unchanged, no `upd_dr`.
- Step gaps and held step:
  - Idle cycles between steps change nothing.
  - `step` held high for 3 cycles with tms=1 from RTI → SelDR, SelIR, TLR.
  - `reset_n`=0 during ShDR → TLR with `dr`=0.
